// File: rtl/noc_vchannel_demux_if.sv
// Link-side and consumer-side signal bundle for the virtual-channel demultiplexer.
// The slave modport is the demux view; the master modport drives the link and consumes flits.
interface noc_vchannel_demux_if #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned CHANNELS   = 7
) ();

  logic [FLIT_WIDTH-1:0]          in_flit;
  logic                           in_last;
  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS-1:0]            in_ready;
  logic [CHANNELS*FLIT_WIDTH-1:0] out_flit;
  logic [CHANNELS-1:0]            out_last;
  logic [CHANNELS-1:0]            out_valid;
  logic [CHANNELS-1:0]            out_ready;
  logic                           err_multi;

  modport master (
    output in_flit,
    output in_last,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_flit,
    input  out_last,
    input  out_valid,
    input  err_multi
  );

  modport slave (
    input  in_flit,
    input  in_last,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_flit,
    output out_last,
    output out_valid,
    output err_multi
  );

endinterface

// File: rtl/noc_vchannel_demux.sv
// Virtual-channel demultiplexer: splits a shared physical link back into independent
// per-channel flit streams, each buffered by its own DEPTH-entry FIFO.
module noc_vchannel_demux #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned CHANNELS   = 7,
  parameter int unsigned DEPTH      = 4
) (
  input logic                  clk,
  input logic                  rst,
  noc_vchannel_demux_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [CHANNELS-1:0]            w_in_ready;
  logic [CHANNELS-1:0]            w_out_valid;
  logic [CHANNELS-1:0]            w_out_last;
  logic [CHANNELS*FLIT_WIDTH-1:0] w_out_flit;
  logic                           w_multi;
  logic                           r_err_multi;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic                  w_push;
    logic                  w_pop;
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic [CntW-1:0]       r_count;
    logic [FLIT_WIDTH:0]   r_mem [DEPTH];

    // Ready/valid come from registered occupancy only, so no comb path link -> consumer.
    assign w_in_ready[c]  = (r_count != CntW'(DEPTH));
    assign w_out_valid[c] = (r_count != '0);
    assign w_push         = bus.in_valid[c] & w_in_ready[c];
    assign w_pop          = w_out_valid[c] & bus.out_ready[c];

    assign w_out_flit[c*FLIT_WIDTH +: FLIT_WIDTH] = r_mem[r_rd_ptr][FLIT_WIDTH-1:0];
    assign w_out_last[c]                          = r_mem[r_rd_ptr][FLIT_WIDTH];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
        if (w_push && !w_pop) begin
          r_count <= r_count + CntW'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - CntW'(1);
        end
      end
    end

    // Storage is deliberately not reset; out_valid masks stale content.
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {bus.in_last, bus.in_flit};
    end
  end

  // More than one valid bit on the link is a protocol violation.
  assign w_multi = |(bus.in_valid & (bus.in_valid - CHANNELS'(1)));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_multi <= 1'b0;
    end else if (w_multi) begin
      r_err_multi <= 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_last;
  assign bus.out_flit  = w_out_flit;
  assign bus.err_multi = r_err_multi;

endmodule

// File: tb/tb_noc_vchannel_demux.sv
// Directed self-checking bench for noc_vchannel_demux with 3 channels of depth 4.
module tb_noc_vchannel_demux;

  localparam int unsigned FW = 32;
  localparam int unsigned CH = 3;
  localparam int unsigned DP = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  noc_vchannel_demux_if #(.FLIT_WIDTH(FW), .CHANNELS(CH)) bus ();

  noc_vchannel_demux #(
    .FLIT_WIDTH (FW),
    .CHANNELS   (CH),
    .DEPTH      (DP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [CH-1:0] vld, input logic [FW-1:0] flit, input logic last);
    bus.in_valid = vld;
    bus.in_flit  = flit;
    bus.in_last  = last;
  endtask

  function automatic logic [FW-1:0] head(input int c);
    return bus.out_flit[c*FW +: FW];
  endfunction

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b0;
    bus.in_valid  = '0;
    bus.in_flit   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = '0;
    step();
    step();
    rst = 1'b1;

    // Reset/idle: put something in ch0, then assert reset mid-cycle with no edge.
    drive(3'b001, 32'h55, 1'b0);
    step();
    drive(3'b000, 32'h0, 1'b0);
    check_eq("pre_rst_valid", bus.out_valid, 3'b001);
    #3;
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", bus.in_ready, 3'b111);
    check_eq("rst_out_valid", bus.out_valid, 3'b000);
    check_eq("rst_err", bus.err_multi, 1'b0);
    step();
    rst = 1'b1;

    // Single flit on channel 1.
    drive(3'b010, 32'hDEADBEEF, 1'b1);
    step();
    drive(3'b000, 32'h0, 1'b0);
    check_eq("single_valid", bus.out_valid, 3'b010);
    check_eq("single_flit", head(1), 32'hDEADBEEF);
    check_eq("single_last", bus.out_last[1], 1'b1);
    bus.out_ready = 3'b010;
    step();
    bus.out_ready = 3'b000;
    check_eq("single_popped", bus.out_valid, 3'b000);

    // Fill channel 0 to full, attempt an extra push, then drain in order.
    for (int i = 0; i < 4; i++) begin
      check_eq("fill_ready", bus.in_ready[0], 1'b1);
      drive(3'b001, FW'(32'h10 + i), 1'b0);
      step();
    end
    check_eq("full_ready", bus.in_ready, 3'b110);
    drive(3'b001, 32'h99, 1'b1);
    step();
    drive(3'b000, 32'h0, 1'b0);
    check_eq("full_hold_ready", bus.in_ready, 3'b110);
    bus.out_ready = 3'b001;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_valid", bus.out_valid[0], 1'b1);
      check_eq("drain_flit", head(0), 32'h10 + i);
      step();
      if (i == 0) check_eq("ready_turnaround", bus.in_ready[0], 1'b1);
    end
    check_eq("drain_empty", bus.out_valid, 3'b000);
    bus.out_ready = 3'b000;

    // Independence: ch2 held full while ch0/ch1 alternate pushes and drain.
    for (int i = 0; i < 4; i++) begin
      drive(3'b100, FW'(32'h20 + i), 1'b0);
      step();
    end
    drive(3'b000, 32'h0, 1'b0);
    check_eq("ch2_full", bus.in_ready, 3'b011);
    bus.out_ready = 3'b011;
    for (int i = 0; i < 6; i++) begin
      drive((i % 2 == 0) ? 3'b001 : 3'b010, FW'(32'h30 + i), 1'b0);
      step();
      check_eq("ilv_valid", bus.out_valid, (i % 2 == 0) ? 3'b101 : 3'b110);
      check_eq("ilv_flit", head(i % 2), 32'h30 + i);
      check_eq("ilv_ch2_head", head(2), 32'h20);
    end
    drive(3'b000, 32'h0, 1'b0);
    step();
    check_eq("ilv_drained", bus.out_valid, 3'b100);
    bus.out_ready = 3'b100;
    for (int i = 0; i < 4; i++) begin
      check_eq("ch2_flit", head(2), 32'h20 + i);
      step();
    end
    check_eq("ch2_empty", bus.out_valid, 3'b000);

    // Streaming through several pointer wraps at one flit per cycle.
    bus.out_ready = 3'b001;
    for (int i = 0; i < 20; i++) begin
      drive(3'b001, FW'(32'h100 + i), i == 19);
      step();
      check_eq("stream_valid", bus.out_valid[0], 1'b1);
      check_eq("stream_flit", head(0), 32'h100 + i);
      check_eq("stream_ready", bus.in_ready[0], 1'b1);
    end
    check_eq("stream_last", bus.out_last[0], 1'b1);
    drive(3'b000, 32'h0, 1'b0);
    step();
    check_eq("stream_empty", bus.out_valid, 3'b000);
    bus.out_ready = 3'b000;

    // Multi-hot protocol violation.
    check_eq("err_clear", bus.err_multi, 1'b0);
    drive(3'b101, 32'hAA, 1'b0);
    step();
    drive(3'b000, 32'h0, 1'b0);
    check_eq("err_set", bus.err_multi, 1'b1);
    check_eq("err_valid", bus.out_valid, 3'b101);
    check_eq("err_ch0", head(0), 32'hAA);
    check_eq("err_ch2", head(2), 32'hAA);
    step();
    step();
    check_eq("err_sticky", bus.err_multi, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    check_eq("err_rst", bus.err_multi, 1'b0);
    check_eq("err_rst_ready", bus.in_ready, 3'b111);
    check_eq("err_rst_valid", bus.out_valid, 3'b000);
    step();
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/noc_vchannel_demux.md
# noc_vchannel_demux

Receive-side counterpart of the virtual-channel multiplexer: takes the shared physical link (one flit/last bus, one valid and one ready bit per virtual channel) and splits it back into independent per-channel flit streams. Each virtual channel gets its own DEPTH-entry FIFO, so back-pressure on one channel never stalls the others on the link. Sits at a router input port or network-adapter ingress, directly downstream of a link driven by the multiplexer.

## Interface
- FLIT_WIDTH, 32, flit payload width in bits
- CHANNELS, 7, number of virtual channels (≥1)
- DEPTH, 4, entries per channel FIFO; power of two, ≥2
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset (assert low: immediate clear; deassert synchronous to clk by the integrator)
- in_flit  input  FLIT_WIDTH  shared link flit
- in_last  input  1  shared link last-flit-of-packet marker
- in_valid  input  CHANNELS  per-channel valid; at most one bit set per cycle by protocol
- in_ready  output  CHANNELS  per-channel ready = that channel's FIFO not full
- out_flit  output  CHANNELS×FLIT_WIDTH  packed per-channel head flit
- out_last  output  CHANNELS  per-channel head last marker
- out_valid  output  CHANNELS  per-channel FIFO not empty
- out_ready  input  CHANNELS  per-channel consumer ready
- err_multi  output  1  sticky: in_valid seen with more than one bit set

## Operation
- Per channel c: FIFO of DEPTH entries, each {last, flit}; write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH), occupancy count (log2(DEPTH)+1 bits, range 0..DEPTH).
- Push c: in_valid[c] & in_ready[c]; writes {in_last, in_flit} at wr_ptr[c], wr_ptr[c]++.
- Pop c: out_valid[c] & out_ready[c]; rd_ptr[c]++.
- count[c] next: +1 on push only, −1 on pop only, unchanged on both or neither.
- in_ready[c] = (count[c] != DEPTH); registered-state only, never depends on in_valid or out_ready.
- out_valid[c] = (count[c] != 0); out_flit[c]/out_last[c] = entry at rd_ptr[c]; undefined content when out_valid[c]=0.
- Channels fully independent; no arbitration, no reordering within a channel.
- Multi-hot in_valid (protocol violation): every channel with valid&ready pushes the same flit; err_multi set to 1 next edge, held until reset.
- in_last carried transparently; no packet-level state or checking.

## Timing
- Reset (rst=0): all pointers and counts 0, err_multi=0 ⇒ in_ready=all 1s, out_valid=all 0s immediately (asynchronous). FIFO storage not reset.
- Latency: flit pushed at edge N is at out_flit[c] with out_valid[c]=1 after edge N (visible cycle N+1); no combinational in→out path.
- Pop at edge N frees a slot; in_ready[c] rises after edge N (one-cycle ready turnaround).
- Full (count=DEPTH): in_ready[c]=0, pushes impossible; pop still allowed, count→DEPTH−1.
- Empty (count=0): out_valid[c]=0, pops impossible; push allowed, count→1.
- Simultaneous push+pop at 0<count<DEPTH: count unchanged, both pointers advance.
- Pointer wrap DEPTH−1→0 transparent; order preserved.
- Sustained throughput: 1 flit/cycle per channel when out_ready held high, across any number of wraps.
- Reset mid-packet: all buffered flits discarded; partial packets are the integrator's concern.

## Test plan
- Reset/idle: CHANNELS=3, DEPTH=4, drive rst=0 mid-cycle → in_ready=3'b111, out_valid=3'b000, err_multi=0 without a clock edge.
- Single flit: push 0xDEADBEEF, last=1 on channel 1 → next cycle out_valid=3'b010, out_flit[1]=0xDEADBEEF, out_last[1]=1; pop → out_valid=0.
- Fill/full: out_ready=0, push 4 flits 0x10..0x13 on channel 0 → in_ready[0]=0 after 4th edge, channel 1/2 ready stay 1; release out_ready → pops 0x10,0x11,0x12,0x13 in order, in_ready[0]=1 one cycle after first pop.
- Independence: channel 2 blocked full, interleave pushes on channels 0/1 with out_ready=3'b011 → channels 0/1 stream 1 flit/cycle, channel 2 content intact.
- Streaming wrap: 20 flits back-to-back on channel 0, out_ready=1 → 20 flits out in order, count never exceeds 1, no bubbles after first.
- Protocol error: in_valid=3'b101, flit 0xAA → err_multi=1 next cycle, channels 0 and 2 both hold 0xAA, err_multi stays 1 until rst=0.
